// File: rtl/pc_fetch_unit.sv
// PC register and single-slot instruction fetch sequencer.
// Feeds decode one instruction at a time over a req/ready memory handshake.
module pc_fetch_unit #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_sel,
  input  logic [WIDTH-1:0] br_target,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic [WIDTH-1:0] instr_in,
  output logic [WIDTH-1:0] instr_out,
  output logic             instr_valid,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus4
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_REDIR
  } state_e;

  localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] pc_out_q, pc_out_d;
  logic             valid_q, valid_d;

  logic             in_fetch;
  logic             slot_held;
  logic             complete;
  logic             redirect;
  logic [WIDTH-1:0] seq_pc;

  assign seq_pc    = pc_q + FOUR;
  assign in_fetch  = (state_q == S_FETCH);
  assign slot_held = stall & valid_q;

  // Request drops while decode holds a live instruction.
  assign imem_req  = in_fetch & ~slot_held;
  assign complete  = imem_req & imem_ready;
  assign redirect  = br_sel & (state_q != S_IDLE);

  assign imem_addr   = pc_q;
  assign pc_plus4    = seq_pc;
  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign pc_out      = pc_out_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (redirect) begin
          pc_d    = br_target;
          valid_d = 1'b0;
          state_d = S_REDIR;
        end else if (complete) begin
          instr_d  = instr_in;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          pc_d     = seq_pc;
        end else if (!stall) begin
          valid_d = 1'b0;
        end
      end
      S_REDIR: begin
        valid_d = 1'b0;
        if (redirect) begin
          pc_d    = br_target;
          state_d = S_REDIR;
        end else begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_ADDR;
      instr_q  <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
    end
  end

  // A killed or not-yet-started fetch never leaves a live slot.
  a_redir_empty: assert property (
    @(posedge clk) disable iff (reset)
    (state_q == S_REDIR) |-> !valid_q
  );

  a_idle_empty: assert property (
    @(posedge clk) disable iff (reset)
    (state_q == S_IDLE) |-> (!valid_q && !imem_req)
  );

endmodule
